// File: rtl/sh4_fetch_redirect_pkg.sv
// Shared types and constants for the SH-4 fetch redirect unit: state encoding,
// reset fetch address and a helper for halfword-aligning branch targets.
package sh4_fetch_redirect_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hA000_0000;

  typedef enum logic [0:0] {
    ST_SEQ     = 1'b0,
    ST_DS_WAIT = 1'b1
  } fr_state_e;

  function automatic logic [31:0] align_half(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/sh4_fetch_redirect_if.sv
// Bundle between the redirect unit and its surroundings: branch/exception inputs,
// the if_req/if_ready fetch handshake, registered pulses and the debug state.
interface sh4_fetch_redirect_if;
  import sh4_fetch_redirect_pkg::*;

  logic        br_valid;
  logic        br_taken;
  logic        br_delayslot;
  logic        br_write_pr;
  logic [31:0] br_target;
  logic [31:0] br_pc;
  logic        ds_retire;
  logic        exc_valid;
  logic [31:0] exc_vector;

  // Handshake: a fetch of if_addr transfers on a rising edge where if_req and
  // if_ready are both high; while if_ready is low and no redirect occurs the
  // request and address stay stable; a redirect may withdraw if_req at any time.
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;

  logic        flush;
  logic        pr_wen;
  logic [31:0] pr_wdata;
  logic        addr_err;
  logic        slot_illegal;
  fr_state_e   state;

  modport master (
    input  br_valid, br_taken, br_delayslot, br_write_pr, br_target, br_pc,
    input  ds_retire, exc_valid, exc_vector, if_ready,
    output if_req, if_addr, flush, pr_wen, pr_wdata, addr_err, slot_illegal, state
  );

  modport slave (
    output br_valid, br_taken, br_delayslot, br_write_pr, br_target, br_pc,
    output ds_retire, exc_valid, exc_vector, if_ready,
    input  if_req, if_addr, flush, pr_wen, pr_wdata, addr_err, slot_illegal, state
  );

endinterface

// File: rtl/sh4_fetch_redirect.sv
// SH-4 fetch address sequencer: sequential halfword fetch, immediate and
// delay-slot branch redirects, exception redirects, PR writes and error pulses.
module sh4_fetch_redirect
  import sh4_fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sh4_fetch_redirect_if.master  bus
);

  fr_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] pr_wdata_q, pr_wdata_d;
  logic        run_q;
  logic        flush_q, flush_d;
  logic        pr_wen_q, pr_wen_d;
  logic        addr_err_q, addr_err_d;
  logic        slot_illegal_q, slot_illegal_d;
  logic        req;
  logic        taken;

  assign taken = bus.br_valid & bus.br_taken;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_d         = pend_q;
    pr_wdata_d     = pr_wdata_q;
    flush_d        = 1'b0;
    pr_wen_d       = 1'b0;
    addr_err_d     = 1'b0;
    slot_illegal_d = 1'b0;
    req            = 1'b0;

    // Exceptions win over everything, including a branch in the same cycle.
    if (bus.exc_valid) begin
      pc_d    = bus.exc_vector;
      pend_d  = '0;
      state_d = ST_SEQ;
      flush_d = 1'b1;
    end else if (state_q == ST_SEQ) begin
      if (taken) begin
        addr_err_d = bus.br_target[0];
        if (bus.br_write_pr) begin
          pr_wen_d   = 1'b1;
          pr_wdata_d = bus.br_pc + 32'd4;
        end
        if (bus.br_delayslot) begin
          pend_d  = align_half(bus.br_target);
          state_d = ST_DS_WAIT;
        end else begin
          pc_d    = align_half(bus.br_target);
          flush_d = 1'b1;
        end
      end else begin
        // run_q keeps the request low until the first edge after reset release.
        req = run_q;
        if (req && bus.if_ready) pc_d = pc_q + 32'd2;
      end
    end else begin
      // A branch inside a delay slot is illegal and otherwise ignored.
      slot_illegal_d = bus.br_valid;
      if (bus.ds_retire) begin
        pc_d    = pend_q;
        state_d = ST_SEQ;
        flush_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SEQ;
      pc_q           <= RESET_PC;
      pend_q         <= '0;
      pr_wdata_q     <= '0;
      run_q          <= 1'b0;
      flush_q        <= 1'b0;
      pr_wen_q       <= 1'b0;
      addr_err_q     <= 1'b0;
      slot_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_q         <= pend_d;
      pr_wdata_q     <= pr_wdata_d;
      run_q          <= 1'b1;
      flush_q        <= flush_d;
      pr_wen_q       <= pr_wen_d;
      addr_err_q     <= addr_err_d;
      slot_illegal_q <= slot_illegal_d;
    end
  end

  assign bus.if_req       = req;
  assign bus.if_addr      = pc_q;
  assign bus.flush        = flush_q;
  assign bus.pr_wen       = pr_wen_q;
  assign bus.pr_wdata     = pr_wdata_q;
  assign bus.addr_err     = addr_err_q;
  assign bus.slot_illegal = slot_illegal_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_sh4_fetch_redirect.sv
// Cycle-by-cycle vector bench for sh4_fetch_redirect: a table of inputs with
// hand-computed outputs, plus hand-written reset sequences.
module tb_sh4_fetch_redirect;
  import sh4_fetch_redirect_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sh4_fetch_redirect_if bus ();

  sh4_fetch_redirect #(.RESET_PC(32'hA000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, bv, bt, bds, bwp;
    logic [31:0] tgt, bpc;
    logic        dsr, exv;
    logic [31:0] evec;
    logic        ereq;
    logic [31:0] eaddr;
    logic        efl, eprw;
    logic [31:0] eprd;
    logic        eae, esi, est;
  } vec_t;

  vec_t vecs[$];

  localparam logic S = 1'b0;
  localparam logic D = 1'b1;
  localparam logic [31:0] P = 32'h8C00_0024;

  task automatic add(input logic rdy, bv, bt, bds, bwp, input logic [31:0] tgt, bpc,
                     input logic dsr, exv, input logic [31:0] evec,
                     input logic ereq, input logic [31:0] eaddr, input logic efl, eprw,
                     input logic [31:0] eprd, input logic eae, esi, est);
    vec_t v;
    v.rdy = rdy; v.bv = bv; v.bt = bt; v.bds = bds; v.bwp = bwp;
    v.tgt = tgt; v.bpc = bpc; v.dsr = dsr; v.exv = exv; v.evec = evec;
    v.ereq = ereq; v.eaddr = eaddr; v.efl = efl; v.eprw = eprw; v.eprd = eprd;
    v.eae = eae; v.esi = esi; v.est = est;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, bv, bt, bds, bwp, input logic [31:0] tgt, bpc,
                       input logic dsr, exv, input logic [31:0] evec);
    bus.if_ready = rdy; bus.br_valid = bv; bus.br_taken = bt; bus.br_delayslot = bds;
    bus.br_write_pr = bwp; bus.br_target = tgt; bus.br_pc = bpc;
    bus.ds_retire = dsr; bus.exc_valid = exv; bus.exc_vector = evec;
  endtask

  task automatic idle(input logic rdy);
    drive(rdy, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic chk_pulses_zero(input string tag);
    chk({tag, "_flush"}, 32'(bus.flush), 32'h0);
    chk({tag, "_pr_wen"}, 32'(bus.pr_wen), 32'h0);
    chk({tag, "_pr_wdata"}, bus.pr_wdata, 32'h0);
    chk({tag, "_addr_err"}, 32'(bus.addr_err), 32'h0);
    chk({tag, "_slot_illegal"}, 32'(bus.slot_illegal), 32'h0);
  endtask

  initial begin
    idle(1'b1);

    // rdy bv bt bds bwp tgt bpc dsr exv evec | req addr flush prw prd ae si st
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'hA000_0000,0,0,32'h0,0,0,S);
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'hA000_0002,0,0,32'h0,0,0,S);
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'hA000_0004,0,0,32'h0,0,0,S);
    // BRA with delay slot
    add(1,1,1,1,0,32'h8C00_0100,32'h8C00_0010,0,0,32'h0, 0,32'hA000_0006,0,0,32'h0,0,0,S);
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           0,32'hA000_0006,0,0,32'h0,0,0,D);
    add(0,0,0,0,0,32'h0,32'h0,1,0,32'h0,           0,32'hA000_0006,0,0,32'h0,0,0,D);
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0100,1,0,32'h0,0,0,S);
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0102,0,0,32'h0,0,0,S);
    // BSR writes PR
    add(1,1,1,1,1,32'h8C00_0200,32'h8C00_0020,0,0,32'h0, 0,32'h8C00_0104,0,0,32'h0,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           0,32'h8C00_0104,0,1,P,0,0,D);
    add(0,0,0,0,0,32'h0,32'h0,1,0,32'h0,           0,32'h8C00_0104,0,0,P,0,0,D);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0200,1,0,P,0,0,S);
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0200,0,0,P,0,0,S);
    // immediate branch to 8C000008, then stall for 4 cycles
    add(1,1,1,0,0,32'h8C00_0008,32'h8C00_0200,0,0,32'h0, 0,32'h8C00_0202,0,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0008,1,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0008,0,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0008,0,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0008,0,0,P,0,0,S);
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0008,0,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_000A,0,0,P,0,0,S);
    // not-taken branch with write_pr: no effect, fetch continues
    add(1,1,0,0,1,32'h8C00_0F00,32'h8C00_000A,0,0,32'h0, 1,32'h8C00_000A,0,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_000C,0,0,P,0,0,S);
    // exception coincident with ds_retire
    add(1,1,1,1,0,32'h8C00_0400,32'h8C00_000A,0,0,32'h0, 0,32'h8C00_000C,0,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,1,1,32'h8C00_0600,   0,32'h8C00_000C,0,0,P,0,0,D);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0600,1,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0600,0,0,P,0,0,S);
    // branch inside delay slot, same cycle as ds_retire
    add(1,1,1,1,0,32'h8C00_0700,32'h8C00_0600,0,0,32'h0, 0,32'h8C00_0600,0,0,P,0,0,S);
    add(0,1,1,0,1,32'h8C00_0800,32'h8C00_0700,1,0,32'h0, 0,32'h8C00_0600,0,0,P,0,0,D);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0700,1,0,P,0,1,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0700,0,0,P,0,0,S);
    // exception beats a PR-writing branch
    add(1,1,1,0,1,32'h8C00_0A00,32'h8C00_0700,0,1,32'h8C00_0900, 0,32'h8C00_0700,0,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0900,1,0,P,0,0,S);
    // JMP to odd target
    add(1,1,1,1,0,32'h8C00_0301,32'h8C00_0900,0,0,32'h0, 0,32'h8C00_0900,0,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           0,32'h8C00_0900,0,0,P,1,0,D);
    add(0,0,0,0,0,32'h0,32'h0,1,0,32'h0,           0,32'h8C00_0900,0,0,P,0,0,D);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h8C00_0300,1,0,P,0,0,S);
    // wrap from FFFFFFFE to 0
    add(1,1,1,0,0,32'hFFFF_FFFE,32'h8C00_0300,0,0,32'h0, 0,32'h8C00_0300,0,0,P,0,0,S);
    add(1,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'hFFFF_FFFE,1,0,P,0,0,S);
    add(0,0,0,0,0,32'h0,32'h0,0,0,32'h0,           1,32'h0000_0000,0,0,P,0,0,S);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_req", 32'(bus.if_req), 32'h0);
    chk("rst_state", 32'(bus.state), 32'(S));
    chk("rst_if_addr", bus.if_addr, 32'hA000_0000);
    chk_pulses_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_if_req_before_edge", 32'(bus.if_req), 32'h0);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].bv, vecs[i].bt, vecs[i].bds, vecs[i].bwp,
            vecs[i].tgt, vecs[i].bpc, vecs[i].dsr, vecs[i].exv, vecs[i].evec);
      #1;
      chk($sformatf("v%0d_if_req", i), 32'(bus.if_req), 32'(vecs[i].ereq));
      chk($sformatf("v%0d_if_addr", i), bus.if_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].efl));
      chk($sformatf("v%0d_pr_wen", i), 32'(bus.pr_wen), 32'(vecs[i].eprw));
      chk($sformatf("v%0d_pr_wdata", i), bus.pr_wdata, vecs[i].eprd);
      chk($sformatf("v%0d_addr_err", i), 32'(bus.addr_err), 32'(vecs[i].eae));
      chk($sformatf("v%0d_slot_illegal", i), 32'(bus.slot_illegal), 32'(vecs[i].esi));
      chk($sformatf("v%0d_state", i), 32'(bus.state), 32'(vecs[i].est));
      @(negedge clk);
    end

    // reset asserted mid-cycle while in DS_WAIT discards the pending target
    drive(1, 1, 1, 1, 1, 32'h8C00_0B00, 32'h0000_0010, 0, 0, 32'h0);
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("dsr_pre_state", 32'(bus.state), 32'(D));
    #2 rst_n = 1'b0;
    #1;
    chk("dsr_rst_if_req", 32'(bus.if_req), 32'h0);
    chk("dsr_rst_state", 32'(bus.state), 32'(S));
    chk("dsr_rst_if_addr", bus.if_addr, 32'hA000_0000);
    chk_pulses_zero("dsr_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("dsr_release_if_req", 32'(bus.if_req), 32'h0);
    @(negedge clk);
    #1;
    chk("dsr_after_if_req", 32'(bus.if_req), 32'h1);
    chk("dsr_after_if_addr", bus.if_addr, 32'hA000_0000);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("dsr_stale_retire_state", 32'(bus.state), 32'(S));
    chk("dsr_stale_retire_flush", 32'(bus.flush), 32'h0);
    chk("dsr_stale_retire_addr", bus.if_addr, 32'hA000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sh4_fetch_redirect.md
SH4_FETCH_REDIRECT -- requirements
Module: sh4_fetch_redirect

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 32'hA000_0000, fetch address after reset.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 br_valid  in  1  branch-unit result valid, one cycle per resolved branch.
REQ-006 br_taken / br_delayslot / br_write_pr  in  1 each  branch outcome flags.
REQ-007 br_target  in  32  branch target address.
REQ-008 br_pc  in  32  address of the branch instruction.
REQ-009 ds_retire  in  1  delay-slot instruction retired, one-cycle pulse.
REQ-010 exc_valid  in  1 / exc_vector  in  32  exception or interrupt redirect request.
REQ-011 if_req  out  1 / if_addr  out  32 / if_ready  in  1  fetch request handshake.
REQ-012 flush  out  1  kill all fetched, not-yet-issued instructions.
REQ-013 pr_wen  out  1 / pr_wdata  out  32  PR write for BSR/JSR/BSRF.
REQ-014 addr_err  out  1 / slot_illegal  out  1  error pulses.

Function
REQ-015 States SHALL be SEQ and DS_WAIT; a 32-bit pc register and a 32-bit pend register.
REQ-016 In SEQ, if_req=1 and if_addr=pc unless a redirect occurs this cycle.
REQ-017 Accept is if_req&if_ready; on accept, pc<=pc+2, modulo 2^32 (32'hFFFF_FFFE wraps to 0).
REQ-018 While if_ready=0 and no redirect, if_req and if_addr SHALL hold stable.
REQ-019 SEQ, br_valid&br_taken&!br_delayslot: if_req=0 this cycle; pc<=br_target; flush=1 next cycle; stay SEQ.
REQ-020 SEQ, br_valid&br_taken&br_delayslot: if_req=0; pend<=br_target; go DS_WAIT.
REQ-021 DS_WAIT: if_req=0; on ds_retire, pc<=pend, flush=1 next cycle, go SEQ.
REQ-022 br_valid&!br_taken: no state or pc change.
REQ-023 br_valid&br_taken&br_write_pr: pr_wen=1 next cycle for one cycle, pr_wdata=br_pc+4.
REQ-024 Target bit0=1: pc loads target with bit0 cleared; addr_err=1 next cycle.
REQ-025 br_valid in DS_WAIT: branch ignored (no pr_wen); slot_illegal=1 next cycle; ds_retire same cycle still processed.
REQ-026 exc_valid has highest priority in any state: pc<=exc_vector, pend discarded, go SEQ, flush=1 next cycle, if_req=0 this cycle; a coincident branch is ignored with no pr_wen.
REQ-027 flush, pr_wen, addr_err and slot_illegal SHALL be registered single-cycle pulses.
REQ-028 Withdrawing if_req in a redirect cycle with if_ready=0 is permitted; the fetch unit discards it.

Reset
REQ-029 rst_n low: state=SEQ, pc=RESET_PC, pend=0, flush=0, pr_wen=0, pr_wdata=0, addr_err=0, slot_illegal=0.
REQ-030 if_req=0 while rst_n low; 1 from first clock after deassertion, if_addr=RESET_PC.
REQ-031 Reset during DS_WAIT discards the pending target.

Structure
REQ-032 State encodings and RESET_PC default SHALL live in the shared defines file.
REQ-033 Single module, no sub-modules; one next-state always block plus registered outputs.

Verification
REQ-034 Reset release, if_ready=1 for 3 cycles -> if_addr A0000000, A0000002, A0000004.
REQ-035 BRA br_pc=8C000010, target 8C000100 -> DS_WAIT, if_req=0; ds_retire -> flush pulse, next if_addr 8C000100.
REQ-036 BSR br_pc=8C000020, target 8C000200 -> pr_wen pulse, pr_wdata 8C000024; redirect after ds_retire.
REQ-037 if_ready=0 for 4 cycles at pc 8C000008 -> if_addr stable, one increment on accept.
REQ-038 DS_WAIT plus exc_valid vector 8C000600 same cycle as ds_retire -> pc 8C000600, pend dropped, single flush.
REQ-039 JMP target 8C000301 -> addr_err pulse, if_addr 8C000300; pc FFFFFFFE accepted -> next if_addr 00000000.
